// File: rtl/cr_huf_comp_sc_short_if.sv
// Symbol-stream input and short-group output handshake of the short-symbol counter stage.
// master = the counter stage, slave = its environment (producer + insertion sort).
interface cr_huf_comp_sc_short_if #(
  parameter int DAT_WIDTH   = 6,
  parameter int CNT_WIDTH   = 16,
  parameter int SEQID_WIDTH = 8
);
  logic                   in_vld;
  logic [DAT_WIDTH-1:0]   in_sym;
  logic                   in_eob;
  logic [SEQID_WIDTH-1:0] in_seq_id;
  logic                   in_rdy;

  logic [3:0]             sc_is_short_vld;
  logic [DAT_WIDTH-1:0]   sc_is_short_sym0;
  logic [DAT_WIDTH-1:0]   sc_is_short_sym1;
  logic [DAT_WIDTH-1:0]   sc_is_short_sym2;
  logic [DAT_WIDTH-1:0]   sc_is_short_sym3;
  logic [CNT_WIDTH-1:0]   sc_is_short_cnt0;
  logic [CNT_WIDTH-1:0]   sc_is_short_cnt1;
  logic [CNT_WIDTH-1:0]   sc_is_short_cnt2;
  logic [CNT_WIDTH-1:0]   sc_is_short_cnt3;
  logic [SEQID_WIDTH-1:0] sc_is_short_seq_id;
  logic                   sc_is_short_eob;
  logic                   is_sc_short_rd;

  modport master (
    input  in_vld, in_sym, in_eob, in_seq_id, is_sc_short_rd,
    output in_rdy, sc_is_short_vld,
           sc_is_short_sym0, sc_is_short_sym1, sc_is_short_sym2, sc_is_short_sym3,
           sc_is_short_cnt0, sc_is_short_cnt1, sc_is_short_cnt2, sc_is_short_cnt3,
           sc_is_short_seq_id, sc_is_short_eob
  );

  modport slave (
    output in_vld, in_sym, in_eob, in_seq_id, is_sc_short_rd,
    input  in_rdy, sc_is_short_vld,
           sc_is_short_sym0, sc_is_short_sym1, sc_is_short_sym2, sc_is_short_sym3,
           sc_is_short_cnt0, sc_is_short_cnt1, sc_is_short_cnt2, sc_is_short_cnt3,
           sc_is_short_seq_id, sc_is_short_eob
  );
endinterface

// File: rtl/cr_huf_comp_sc_short.sv
// Short-symbol histogram: counts symbols per block, then drains non-zero counts
// four symbols per group to the short insertion sort.
module cr_huf_comp_sc_short #(
  parameter int DAT_WIDTH   = 6,
  parameter int CNT_WIDTH   = 16,
  parameter int SEQID_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cr_huf_comp_sc_short_if.master bus
);
  localparam int unsigned NUM_SYM = 2 ** DAT_WIDTH;
  localparam int unsigned NUM_GRP = NUM_SYM / 4;
  localparam int unsigned GRP_W   = (DAT_WIDTH > 2) ? DAT_WIDTH - 2 : 1;

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t                 state_q, state_d;
  logic [GRP_W-1:0]       grp_q, grp_d;
  logic [SEQID_WIDTH-1:0] seq_q;
  logic [CNT_WIDTH-1:0]   cnt [NUM_SYM];
  logic [NUM_GRP-1:0]     grp_nz;
  logic [CNT_WIDTH-1:0]   lane_cnt [4];
  logic                   above_nz;
  logic                   cur_nz;
  logic                   last_grp;
  logic                   accept;
  logic                   take_sym;
  logic                   take_eob;
  logic [DAT_WIDTH-1:0]   sym_base;

  assign take_sym = (state_q == ACCUM) && bus.in_vld;
  assign take_eob = take_sym && bus.in_eob;

  // One register per symbol so each count has a single driver.
  for (genvar s = 0; s < NUM_SYM; s++) begin : gen_cnt
    localparam logic [DAT_WIDTH-1:0] SYM = DAT_WIDTH'(s);
    localparam logic [GRP_W-1:0]     GRP = GRP_W'(s / 4);
    logic [CNT_WIDTH-1:0] c_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        c_q <= '0;
      end else if (take_sym && bus.in_sym == SYM) begin
        if (c_q != '1) c_q <= c_q + 1'b1;
      end else if (accept && grp_q == GRP) begin
        c_q <= '0;
      end
    end

    assign cnt[s] = c_q;
  end

  always_comb begin
    grp_nz   = '0;
    above_nz = 1'b0;
    for (int unsigned k = 0; k < 4; k++) lane_cnt[k] = '0;
    for (int unsigned g = 0; g < NUM_GRP; g++) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (cnt[4*g+k] != '0) grp_nz[g] = 1'b1;
      end
      if (GRP_W'(g) == grp_q) begin
        for (int unsigned k = 0; k < 4; k++) lane_cnt[k] = cnt[4*g+k];
      end
      if (g > 32'(grp_q)) above_nz = above_nz | grp_nz[g];
    end
  end

  assign cur_nz   = (lane_cnt[0] != '0) || (lane_cnt[1] != '0) ||
                    (lane_cnt[2] != '0) || (lane_cnt[3] != '0);
  assign last_grp = cur_nz && !above_nz;
  assign accept   = (state_q == DRAIN) && cur_nz && bus.is_sc_short_rd;
  assign sym_base = DAT_WIDTH'({grp_q, 2'b00});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      grp_q   <= '0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      grp_q   <= grp_d;
      if (take_eob) seq_q <= bus.in_seq_id;
    end
  end

  // Empty groups advance unconditionally; non-empty groups wait for rd.
  always_comb begin
    state_d = state_q;
    grp_d   = grp_q;
    unique case (state_q)
      ACCUM: begin
        if (take_eob) begin
          state_d = DRAIN;
          grp_d   = '0;
        end
      end
      DRAIN: begin
        if (!cur_nz) begin
          grp_d = grp_q + 1'b1;
        end else if (bus.is_sc_short_rd) begin
          if (last_grp) state_d = ACCUM;
          else          grp_d   = grp_q + 1'b1;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_comb begin
    bus.in_rdy             = 1'b1;
    bus.sc_is_short_vld    = '0;
    bus.sc_is_short_sym0   = '0;
    bus.sc_is_short_sym1   = '0;
    bus.sc_is_short_sym2   = '0;
    bus.sc_is_short_sym3   = '0;
    bus.sc_is_short_cnt0   = '0;
    bus.sc_is_short_cnt1   = '0;
    bus.sc_is_short_cnt2   = '0;
    bus.sc_is_short_cnt3   = '0;
    bus.sc_is_short_seq_id = '0;
    bus.sc_is_short_eob    = 1'b0;
    if (state_q == DRAIN) begin
      bus.in_rdy             = 1'b0;
      bus.sc_is_short_vld    = {lane_cnt[3] != '0, lane_cnt[2] != '0,
                                lane_cnt[1] != '0, lane_cnt[0] != '0};
      bus.sc_is_short_sym0   = sym_base;
      bus.sc_is_short_sym1   = sym_base + DAT_WIDTH'(1);
      bus.sc_is_short_sym2   = sym_base + DAT_WIDTH'(2);
      bus.sc_is_short_sym3   = sym_base + DAT_WIDTH'(3);
      bus.sc_is_short_cnt0   = lane_cnt[0];
      bus.sc_is_short_cnt1   = lane_cnt[1];
      bus.sc_is_short_cnt2   = lane_cnt[2];
      bus.sc_is_short_cnt3   = lane_cnt[3];
      bus.sc_is_short_seq_id = seq_q;
      bus.sc_is_short_eob    = last_grp;
    end
  end
endmodule

// File: doc/cr_huf_comp_sc_short.md
# cr_huf_comp_sc_short

Short-symbol counter stage of the Huffman compressor. It accumulates a per-block histogram of short symbols from the upstream symbol stream. At end of block it drains the non-zero counts, four symbols per group, to the short insertion-sort stage over the `sc_is_short_*` / `is_sc_short_rd` handshake. It sits directly upstream of the short insertion sort and directly downstream of the symbol-stream producer.

## Interface
Parameters:
- `DAT_WIDTH`, default 6: symbol width. `NUM_SYM = 2**DAT_WIDTH`. `DAT_WIDTH` must be ≥ 2.
- `CNT_WIDTH`, default 16: per-symbol count width. Counts saturate.
- `SEQID_WIDTH`, default 8: sequence-id width.

Ports:
- `clk`  in  1  — the single clock.
- `rst_n`  in  1  — synchronous, active-low reset.
- `in_vld`  in  1  — input symbol valid.
- `in_sym`  in  DAT_WIDTH  — input symbol.
- `in_eob`  in  1  — last symbol of the block. Qualified by `in_vld`.
- `in_seq_id`  in  SEQID_WIDTH  — block sequence id. Sampled on the eob beat.
- `in_rdy`  out  1  — block accepts input symbols.
- `sc_is_short_vld`  out  4  — per-lane valid for the group presented.
- `sc_is_short_sym0..3`  out  DAT_WIDTH each  — lane symbols.
- `sc_is_short_cnt0..3`  out  CNT_WIDTH each  — lane counts.
- `sc_is_short_seq_id`  out  SEQID_WIDTH  — seq id of the block being drained.
- `sc_is_short_eob`  out  1  — the presented group is the last non-zero group of the block.
- `is_sc_short_rd`  in  1  — consumer accepts the presented group.

## Operation
- Storage: a `NUM_SYM` × `CNT_WIDTH` flop array `cnt[]`, a state bit (ACCUM/DRAIN), a group pointer `grp` (`DAT_WIDTH-2` bits), and a seq_id register.

ACCUM:
- `in_rdy` = 1 and all `sc_is_short_*` outputs = 0.
- On `in_vld`: `cnt[in_sym]` += 1, saturating at `2**CNT_WIDTH-1`.
- On `in_vld & in_eob`: the symbol is counted, `in_seq_id` is captured, `grp` ← 0, and the state becomes DRAIN.
- `in_eob` without `in_vld` is ignored. Every block carries at least one symbol.

DRAIN:
- `in_rdy` = 0. Upstream must not drive `in_vld`; any `in_vld` in DRAIN is ignored.
- Outputs are combinational from the flops:
  - lane k shows symbol `4*grp+k` with count `cnt[4*grp+k]`;
  - `vld[k]` = (count ≠ 0);
  - `eob` = `vld` ≠ 0 AND every count in groups above `grp` is zero;
  - `seq_id` = captured value.
- If `vld` == 0, `grp` advances by 1 next cycle. Zero groups are skipped one per cycle and `eob` = 0 during a skip.
- If `vld` ≠ 0 and `is_sc_short_rd` = 1, the four counts of the group are cleared, then:
  - if `eob` = 1, the state becomes ACCUM;
  - otherwise `grp` advances by 1.
- `is_sc_short_rd` while `vld` == 0 is ignored.
- After a drain the array is all-zero, so no separate clear phase is needed.
- Reset at any point: all counts = 0, state = ACCUM, `grp` = 0, seq_id = 0.

## Timing
- Reset values: `in_rdy` = 1 (first cycle after reset release); `sc_is_short_vld` = 0; all syms, cnts, seq_id and eob = 0.
- Count update latency: 1 cycle. A symbol accepted in cycle t is visible in `cnt` at t+1.
- Eob beat accepted in cycle E:
  - E+1: DRAIN, `in_rdy` = 0, group 0 presented.
  - First non-zero group appears at E+1+(number of leading zero groups).
- Each accepted group takes 1 cycle when `rd` is held high. A stalled group holds all outputs stable until `rd`.
- Final group accepted in cycle F: F+1 is ACCUM with `in_rdy` = 1 and outputs 0.
- Minimum block-to-block gap: drain cycles + 1.

## Test plan
- Block 5,5,5,9 with eob on 9, seq_id=3, `rd` tied high:
  - group 1: `vld`=4'b0010, `sym1`=5, `cnt1`=3, `eob`=0;
  - group 2: `vld`=4'b0010, `sym1`=9, `cnt1`=1, `eob`=1, `seq_id`=3;
  - groups 0 and 3..15 skipped; `in_rdy`=1 the cycle after the group 2 accept.
- Same block, `rd` held low 10 cycles on group 1 → outputs bit-identical every stalled cycle. Release `rd` → group 2 next cycle.
- `CNT_WIDTH`=4, 20× symbol 0 then eob on symbol 0 → `cnt0`=15 (saturated), `vld`=4'b0001, `eob`=1.
- All 64 symbols once each, last with eob → 16 groups, each `vld`=4'hF, all cnt=1, `eob` only on group 15. 16 `rd` accepts exactly.
- Assert `rst_n`=0 for one cycle mid-drain after group 1 is accepted → next cycle `vld`=0 and `in_rdy`=1. A following block of symbol 2 only drains one group: `cnt2`=1, `eob`=1.
- Two back-to-back blocks (7,7 seq 1; 7 seq 2) → second drain reports `cnt3`=1 for sym 7 and `seq_id`=2, showing no carry-over from the first block.
